ff_conv_reg: RTL and testbench

FF_CONV_REG -- requirements
Module: ff_conv_reg

---
 rtl/ff_conv_reg.sv | 104 ++++++++++
 tb/tb_ff_conv_reg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ff_conv_reg.sv
// Convertible WIDTH-bit register: each bit acts as a D, T, JK or SR flip-flop, selected by a latched mode.
// Define FF_CONV_SR_CHECK_EN to hold S=R=1 bits and raise a sticky err; otherwise S=R=1 is set-dominant.
module ff_conv_reg #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       mode_in,
  input  logic             mode_ld,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             spre,
  input  logic             sclr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [1:0]       mode,
  output logic             chg,
  output logic             err
);

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } ff_mode_e;

  ff_mode_e         mode_q, mode_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] func_q;
  logic             chg_q, chg_d;
  logic             err_q, err_d;
  logic             sr_illegal;
  logic [WIDTH-1:0] sr_both;

  assign sr_both = a & b;

  always_comb begin
    func_q     = q_q;
    sr_illegal = 1'b0;
    unique case (mode_q)
      MODE_D:  func_q = a;
      MODE_T:  func_q = q_q ^ a;
      MODE_JK: func_q = (a & ~q_q) | (~b & q_q);
      MODE_SR: begin
`ifdef FF_CONV_SR_CHECK_EN
        func_q     = ((a | (~b & q_q)) & ~sr_both) | (q_q & sr_both);
        sr_illegal = |sr_both;
`else
        func_q     = a | (~b & q_q);
`endif
      end
      default: func_q = q_q;
    endcase
  end

  // sclr beats spre, which beats the mode function; mode changes only take effect next edge.
  always_comb begin
    q_d    = q_q;
    mode_d = mode_q;
    err_d  = err_q;
    if (sclr) begin
      q_d = '0;
    end else if (spre) begin
      q_d = '1;
    end else if (en) begin
      q_d = func_q;
`ifdef FF_CONV_SR_CHECK_EN
      err_d = err_q | sr_illegal;
`endif
    end
    if (mode_ld) begin
      mode_d = ff_mode_e'(mode_in);
    end
    chg_d = (q_d != q_q);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_q    <= RST_VAL;
      mode_q <= MODE_D;
      chg_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      mode_q <= mode_d;
      chg_q  <= chg_d;
      err_q  <= err_d;
    end
  end

  assign q    = q_q;
  assign qbar = ~q_q;
  assign mode = mode_q;
  assign chg  = chg_q;
`ifdef FF_CONV_SR_CHECK_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_ff_conv_reg.sv
// Self-checking bench for ff_conv_reg (WIDTH=8, RST_VAL=8'hA5) using an expected-value queue.
module tb_ff_conv_reg;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] mode_in = 2'b00;
  logic       mode_ld = 1'b0;
  logic       en = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       spre = 1'b0;
  logic       sclr = 1'b0;
  logic [7:0] q, qbar;
  logic [1:0] mode;
  logic       chg, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] q;
    logic [1:0] mode;
    logic       chg;
    logic       err;
    string      tag;
  } expect_t;

  expect_t scoreQ[$];

  logic [7:0] mdlQ;
  logic [1:0] mdlMode;
  logic       mdlErr;

  ff_conv_reg #(.WIDTH(8), .RST_VAL(8'hA5)) dut (
    .clk(clk), .clr(clr), .mode_in(mode_in), .mode_ld(mode_ld), .en(en),
    .a(a), .b(b), .spre(spre), .sclr(sclr),
    .q(q), .qbar(qbar), .mode(mode), .chg(chg), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] modelNext(input logic [7:0] cur, input logic [1:0] md, input logic enV,
                                           input logic [7:0] av, input logic [7:0] bv,
                                           input logic spreV, input logic sclrV, output logic illegal);
    logic [7:0] nxt;
    nxt = cur;
    illegal = 1'b0;
    if (sclrV) nxt = 8'h00;
    else if (spreV) nxt = 8'hFF;
    else if (enV) begin
      for (int i = 0; i < 8; i++) begin
        case (md)
          2'b00: nxt[i] = av[i];
          2'b01: nxt[i] = av[i] ? ~cur[i] : cur[i];
          2'b10: case ({av[i], bv[i]})
                   2'b00: nxt[i] = cur[i];
                   2'b01: nxt[i] = 1'b0;
                   2'b10: nxt[i] = 1'b1;
                   default: nxt[i] = ~cur[i];
                 endcase
          default: case ({av[i], bv[i]})
                     2'b00: nxt[i] = cur[i];
                     2'b01: nxt[i] = 1'b0;
                     2'b10: nxt[i] = 1'b1;
                     default: begin
`ifdef FF_CONV_SR_CHECK_EN
                       nxt[i] = cur[i];
                       illegal = 1'b1;
`else
                       nxt[i] = 1'b1;
`endif
                     end
                   endcase
        endcase
      end
    end
    return nxt;
  endfunction

  task automatic compareOutputs(input expect_t e);
    checkOutput({e.tag, ".q"}, {24'd0, q}, {24'd0, e.q});
    checkOutput({e.tag, ".qbar"}, {24'd0, qbar}, {24'd0, ~e.q});
    checkOutput({e.tag, ".mode"}, {30'd0, mode}, {30'd0, e.mode});
    checkOutput({e.tag, ".chg"}, {31'd0, chg}, {31'd0, e.chg});
    checkOutput({e.tag, ".err"}, {31'd0, err}, {31'd0, e.err});
  endtask

  task automatic applyStimulus(input logic ld, input logic [1:0] mi, input logic e,
                               input logic [7:0] av, input logic [7:0] bv,
                               input logic sp, input logic sc, input string tag);
    expect_t ex;
    logic illegal;
    logic [7:0] nxt;
    @(negedge clk);
    mode_ld = ld; mode_in = mi; en = e; a = av; b = bv; spre = sp; sclr = sc;
    nxt = modelNext(mdlQ, mdlMode, e, av, bv, sp, sc, illegal);
    ex.chg = (nxt != mdlQ);
    ex.q = nxt;
`ifdef FF_CONV_SR_CHECK_EN
    mdlErr = mdlErr | illegal;
`endif
    if (ld) mdlMode = mi;
    ex.mode = mdlMode;
    ex.err = mdlErr;
    ex.tag = tag;
    mdlQ = nxt;
    scoreQ.push_back(ex);
    @(posedge clk);
    #1;
    if (scoreQ.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      compareOutputs(scoreQ.pop_front());
    end
  endtask

  task automatic resetModel();
    mdlQ = 8'hA5; mdlMode = 2'b00; mdlErr = 1'b0;
  endtask

  initial begin
    expect_t rstExp;
    logic [7:0] heldQ;
    rstExp.q = 8'hA5; rstExp.mode = 2'b00; rstExp.chg = 1'b0; rstExp.err = 1'b0;

    // Mid-cycle async reset, checked before any rising edge
    #12 clr = 1'b1;
    #1;
    rstExp.tag = "rst_async";
    compareOutputs(rstExp);

    // Inputs ignored while clr is held
    mode_ld = 1'b1; mode_in = 2'b11; en = 1'b1; a = 8'hFF; b = 8'h0F; spre = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstExp.tag = "rst_hold";
    compareOutputs(rstExp);
    @(negedge clk);
    mode_ld = 1'b0; en = 1'b0; spre = 1'b0;
    clr = 1'b0;
    resetModel();

    // First edge after release: hold, no chg
    applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "post_rst");

    // D then T
    applyStimulus(1'b0, 2'b00, 1'b1, 8'h3C, 8'h00, 1'b0, 1'b0, "d_3c");
    applyStimulus(1'b1, 2'b01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "ld_t");
    applyStimulus(1'b0, 2'b00, 1'b1, 8'hFF, 8'hAA, 1'b0, 1'b0, "t_ff1");
    checkOutput("t_c3_const", {24'd0, q}, 32'hC3);
    applyStimulus(1'b0, 2'b00, 1'b1, 8'hFF, 8'h55, 1'b0, 1'b0, "t_ff2");
    checkOutput("t_3c_const", {24'd0, q}, 32'h3C);

    // Back to D, then load JK on the same edge as a D write of 0F
    applyStimulus(1'b1, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "ld_d");
    applyStimulus(1'b1, 2'b10, 1'b1, 8'h0F, 8'h00, 1'b0, 1'b0, "d_0f_ld_jk");
    applyStimulus(1'b0, 2'b00, 1'b1, 8'hF0, 8'h3C, 1'b0, 1'b0, "jk");
    checkOutput("jk_f3_const", {24'd0, q}, 32'hF3);
    applyStimulus(1'b0, 2'b00, 1'b1, 8'h81, 8'h18, 1'b0, 1'b0, "jk_mix");

    // SR illegal combination, then err stickiness
    applyStimulus(1'b1, 2'b11, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, "ld_sr_clr");
    applyStimulus(1'b0, 2'b00, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0, "sr_11");
`ifdef FF_CONV_SR_CHECK_EN
    checkOutput("sr_11_const", {24'd0, q}, 32'h00);
`else
    checkOutput("sr_11_const", {24'd0, q}, 32'h01);
`endif
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 2'b00, 1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b0, "sr_sticky");
    applyStimulus(1'b0, 2'b00, 1'b1, 8'hC0, 8'h06, 1'b0, 1'b0, "sr_mix");

    // Priority of synchronous controls
    applyStimulus(1'b0, 2'b00, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b1, "spre_sclr");
    applyStimulus(1'b0, 2'b00, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, "spre");
    applyStimulus(1'b1, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "ld_d2");
    applyStimulus(1'b1, 2'b01, 1'b1, 8'h55, 8'h00, 1'b0, 1'b0, "d_55_ld_t");
    checkOutput("d_55_const", {24'd0, q}, 32'h55);
    applyStimulus(1'b0, 2'b00, 1'b1, 8'h0F, 8'h00, 1'b0, 1'b0, "t_after_ld");

    // Hold with random data
    heldQ = mdlQ;
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, 2'b00, 1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b0, "hold");
    checkOutput("hold_const", {24'd0, q}, {24'd0, heldQ});

    // Reset during a pending mode load discards the load
    @(negedge clk);
    mode_ld = 1'b1; mode_in = 2'b10; en = 1'b1; a = 8'hFF;
    #2 clr = 1'b1;
    @(posedge clk);
    #1;
    rstExp.tag = "rst_mid";
    compareOutputs(rstExp);
    @(negedge clk);
    mode_ld = 1'b0; en = 1'b0;
    clr = 1'b0;
    resetModel();
    applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "post_rst2");
    applyStimulus(1'b0, 2'b00, 1'b1, 8'h12, 8'h00, 1'b0, 1'b0, "d_after_rst");

    if (scoreQ.size() != 0) checkOutput("scoreboard_left", scoreQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
